vdp_bus_sync: RTL
=================

# vdp_bus_sync

CPU-side bus front end of the VDP, directly upstream of the register interface. Takes the asynchronous Z8S180 I/O strobes, mode bit and data bus, synchronizes them into the 25 MHz pixel-clock domain and emits one-clock `wr0/wr1/rd0/rd1` ticks plus a held data byte. `wr1_tick`/`rd1_tick`/`dout` feed the register interface's `wr_tick`/`rd_tick`/`din`. `wr0_tick`/`rd0_tick` go to the VRAM port logic.

## Interface
- `SYNC_STAGES`, 2, synchronizer flops per strobe (legal 2..4)
- `FILTER_LEN`, 2, consecutive synchronized samples required to accept a strobe edge (legal 1..15; used only with `VDP_BUS_FILTER_EN`)

- `clk`  in  1  pixel clock, 25 MHz, all state on posedge
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `cpu_ce_n`  in  1  VDP chip select (IORQ & address decode), async, active-low
- `cpu_wr_n`  in  1  CPU write strobe, async, active-low
- `cpu_rd_n`  in  1  CPU read strobe, async, active-low
- `cpu_mode`  in  1  CPU A0: 0 = VRAM data port, 1 = register/status port
- `cpu_din`  in  8  CPU data bus, async
- `wr0_tick`  out  1  one-clock pulse, mode-0 write accepted
- `wr1_tick`  out  1  one-clock pulse, mode-1 write accepted
- `rd0_tick`  out  1  one-clock pulse, mode-0 read accepted
- `rd1_tick`  out  1  one-clock pulse, mode-1 read accepted
- `dout`  out  8  last accepted write byte; held until next write
- `cycle_active`  out  1  high while an accepted CPU cycle is still asserted

## Operation
- Raw strobes: `wr_a = ~cpu_ce_n & ~cpu_wr_n`, `rd_a = ~cpu_ce_n & ~cpu_rd_n`; each through its own `SYNC_STAGES` chain, chain reset value inactive.
- `cpu_din` and `cpu_mode` registered every clk into `din_q`/`mode_q` (reset 0).
- FSM states: `WAIT_IDLE`, `IDLE`, `WR_ACT`, `RD_ACT`.
- `WAIT_IDLE` (reset state): stays until both qualified strobes inactive, then `IDLE`. Strobe held through reset release therefore generates no tick.
- `IDLE`: qualified write active -> `WR_ACT`, assert `wr0_tick` or `wr1_tick` per `mode_q`, `dout <= din_q`. Else qualified read active -> `RD_ACT`, assert `rd0_tick`/`rd1_tick` per `mode_q`.
- Simultaneous qualified write and read in `IDLE`: write wins; read ignored.
- `WR_ACT`/`RD_ACT`: no further ticks; return to `IDLE` only when both qualified strobes inactive (re-asserting wr during a read cycle does not tick).
- `cycle_active` = state is `WR_ACT` or `RD_ACT`.
- `dout` updates only on a write tick; reads never change it.

## Timing
- Reset values: all ticks 0, `dout` 0x00, `cycle_active` 0, state `WAIT_IDLE`, counters 0.
- Define edge k = first posedge sampling raw strobe active.
- Without filter: tick high in cycle following posedge k+`SYNC_STAGES`; exactly 1 clk wide.
- With filter: tick high after posedge k+`SYNC_STAGES`+`FILTER_LEN`-1; exactly 1 clk wide.
- Release to `IDLE`: same latency as acceptance, measured from strobe deassertion.
- Back-to-back: a new cycle ticks no earlier than one clk after `IDLE` is re-entered; two CPU writes separated by >= 1 inactive qualified sample each produce one tick.
- `cpu_din`/`cpu_mode` must be stable >= `SYNC_STAGES`+`FILTER_LEN` clk before and throughout the tick cycle (Z8S180 holds data for whole WR low).
- Async reset mid-cycle: outputs clear immediately; no tick for the interrupted cycle.

## Configuration
- `VDP_BUS_FILTER_EN` defined: per-strobe 4-bit run counter; qualified level changes only after `FILTER_LEN` consecutive equal synchronized samples; pulses shorter than `FILTER_LEN` clk ignored.
- Undefined: qualified strobe = synchronizer output directly; `FILTER_LEN` ignored; a 1-clk glitch that is sampled produces a tick.

## Test plan
- Reset: hold `reset`=0 with `cpu_ce_n`=`cpu_wr_n`=0, release -> no tick until strobe released and re-asserted; `dout`=0x00 throughout.
- Write mode 1: `cpu_din`=0xEE, `cpu_mode`=1, strobe low 8 clk -> single `wr1_tick` at defined latency, `dout`=0xEE, `cycle_active` high until release; then 0x80 -> second `wr1_tick`, `dout`=0x80.
- Read mode 1 and mode 0: `cpu_rd_n` low 8 clk each -> one `rd1_tick`, then one `rd0_tick`; `dout` unchanged.
- Simultaneous `cpu_wr_n`=`cpu_rd_n`=0, mode 0, din 0x5A -> `wr0_tick` only, `dout`=0x5A, no read tick.
- Filter (macro defined, `FILTER_LEN`=3): 2-clk strobe pulse -> no tick; 3-clk pulse -> one tick. Macro undefined: 2-clk pulse -> one tick.
- Async reset asserted during `WR_ACT` -> ticks/`cycle_active` 0 immediately; state `WAIT_IDLE`; no tick after release while strobe still low.

Source files
------------

// File: rtl/vdp_bus_sync_if.sv
// vdp_bus_sync_if: CPU strobe/data bundle and VDP-side tick outputs.
// master = CPU/bus driver side, slave = vdp_bus_sync.
interface vdp_bus_sync_if;
  logic       cpu_ce_n;
  logic       cpu_wr_n;
  logic       cpu_rd_n;
  logic       cpu_mode;
  logic [7:0] cpu_din;
  logic       wr0_tick;
  logic       wr1_tick;
  logic       rd0_tick;
  logic       rd1_tick;
  logic [7:0] dout;
  logic       cycle_active;

  modport master (
    output cpu_ce_n, cpu_wr_n, cpu_rd_n,
    output cpu_mode, cpu_din,
    input  wr0_tick, wr1_tick,
    input  rd0_tick, rd1_tick,
    input  dout, cycle_active
  );

  modport slave (
    input  cpu_ce_n, cpu_wr_n, cpu_rd_n,
    input  cpu_mode, cpu_din,
    output wr0_tick, wr1_tick,
    output rd0_tick, rd1_tick,
    output dout, cycle_active
  );
endinterface

// File: rtl/vdp_bus_sync.sv
// vdp_bus_sync: Z8S180 strobe synchronizer and one-clock tick generator.
// Define VDP_BUS_FILTER_EN to add the FILTER_LEN run-length strobe filter.
module vdp_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic           clk,
  input  logic           reset,
  vdp_bus_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    WR_ACT,
    RD_ACT
  } state_t;

  // Chains reset inactive, so a strobe held through reset is only
  // visible after the chain refills; wait that long before idling.
  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
  localparam logic [4:0] SETTLE_M1 = 5'(SETTLE - 1);

  logic                   w_wr_a;
  logic                   w_rd_a;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic                   w_wr_s;
  logic                   w_rd_s;
  logic                   w_wr_q;
  logic                   w_rd_q;
  logic [7:0]             r_din_q;
  logic                   r_mode_q;

  state_t     r_state;
  state_t     w_state_n;
  logic [4:0] r_settle;
  logic [4:0] w_settle_n;
  logic       r_wr0;
  logic       r_wr1;
  logic       r_rd0;
  logic       r_rd1;
  logic       w_wr0_n;
  logic       w_wr1_n;
  logic       w_rd0_n;
  logic       w_rd1_n;
  logic       w_load;
  logic [7:0] r_dout;

  assign w_wr_a = ~bus.cpu_ce_n & ~bus.cpu_wr_n;
  assign w_rd_a = ~bus.cpu_ce_n & ~bus.cpu_rd_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_sync <= '0;
      r_rd_sync <= '0;
      r_din_q   <= 8'h00;
      r_mode_q  <= 1'b0;
    end else begin
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], w_wr_a};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], w_rd_a};
      r_din_q   <= bus.cpu_din;
      r_mode_q  <= bus.cpu_mode;
    end
  end

  assign w_wr_s = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s = r_rd_sync[SYNC_STAGES-1];

`ifdef VDP_BUS_FILTER_EN
  localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);

  logic       r_wr_flt;
  logic       r_rd_flt;
  logic [3:0] r_wr_cnt;
  logic [3:0] r_rd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_flt <= 1'b0;
      r_wr_cnt <= 4'd0;
    end else if (w_wr_s == r_wr_flt) begin
      r_wr_cnt <= 4'd0;
    end else if (r_wr_cnt == FL_M1) begin
      r_wr_flt <= w_wr_s;
      r_wr_cnt <= 4'd0;
    end else begin
      r_wr_cnt <= r_wr_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_flt <= 1'b0;
      r_rd_cnt <= 4'd0;
    end else if (w_rd_s == r_rd_flt) begin
      r_rd_cnt <= 4'd0;
    end else if (r_rd_cnt == FL_M1) begin
      r_rd_flt <= w_rd_s;
      r_rd_cnt <= 4'd0;
    end else begin
      r_rd_cnt <= r_rd_cnt + 4'd1;
    end
  end

  // Qualified level flips on the FILTER_LEN-th matching sample itself.
  assign w_wr_q = (w_wr_s != r_wr_flt && r_wr_cnt == FL_M1)
                ? w_wr_s : r_wr_flt;
  assign w_rd_q = (w_rd_s != r_rd_flt && r_rd_cnt == FL_M1)
                ? w_rd_s : r_rd_flt;
`else
  assign w_wr_q = w_wr_s;
  assign w_rd_q = w_rd_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= WAIT_IDLE;
      r_settle <= 5'd0;
      r_wr0    <= 1'b0;
      r_wr1    <= 1'b0;
      r_rd0    <= 1'b0;
      r_rd1    <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      r_state  <= w_state_n;
      r_settle <= w_settle_n;
      r_wr0    <= w_wr0_n;
      r_wr1    <= w_wr1_n;
      r_rd0    <= w_rd0_n;
      r_rd1    <= w_rd1_n;
      if (w_load) r_dout <= r_din_q;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_settle_n = 5'd0;
    w_wr0_n    = 1'b0;
    w_wr1_n    = 1'b0;
    w_rd0_n    = 1'b0;
    w_rd1_n    = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      WAIT_IDLE: begin
        if (!w_wr_q && !w_rd_q) begin
          if (r_settle == SETTLE_M1) w_state_n = IDLE;
          else w_settle_n = r_settle + 5'd1;
        end
      end
      IDLE: begin
        if (w_wr_q) begin
          w_state_n = WR_ACT;
          w_wr0_n   = ~r_mode_q;
          w_wr1_n   = r_mode_q;
          w_load    = 1'b1;
        end else if (w_rd_q) begin
          w_state_n = RD_ACT;
          w_rd0_n   = ~r_mode_q;
          w_rd1_n   = r_mode_q;
        end
      end
      WR_ACT, RD_ACT: begin
        if (!w_wr_q && !w_rd_q) w_state_n = IDLE;
      end
      default: w_state_n = WAIT_IDLE;
    endcase
  end

  assign bus.wr0_tick     = r_wr0;
  assign bus.wr1_tick     = r_wr1;
  assign bus.rd0_tick     = r_rd0;
  assign bus.rd1_tick     = r_rd1;
  assign bus.dout         = r_dout;
  assign bus.cycle_active = (r_state == WR_ACT) || (r_state == RD_ACT);

endmodule
